// File: rtl/c3lib_deglitch_pkg.sv
// Shared helpers for the synchronized-bus deglitch filter: counter sizing,
// parameter legality checks and reset-level derivation.
package c3lib_deglitch_pkg;

  // Counter width for a filter of n samples; at least one bit so the
  // FILTER_CYCLES=1 case still has a legal (always-zero) counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit filter_cycles_legal(input int n);
    return (n >= 1);
  endfunction

  function automatic bit dwidth_legal(input int w);
    return (w >= 1);
  endfunction

  // Any nonzero RESET_VAL means every filtered bit resets high.
  function automatic logic reset_bit(input int rv);
    return (rv != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/c3lib_deglitch_bit.sv
// Single-bit glitch filter: holds the accepted level, the run counter of
// consecutive mismatching samples, and the registered rise/fall pulses.
module c3lib_deglitch_bit
  import c3lib_deglitch_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic filt_en,
  input  logic din,
  output logic f,
  output logic rise,
  output logic fall,
  output logic edge_nxt
);

  localparam int CNT_W = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             f_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      f    <= RESET_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      f    <= f_nxt;
      cnt  <= cnt_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

  // A match, an acceptance or bypass all leave the counter at zero, so
  // partial counts never carry over between mismatch runs.
  always_comb begin
    f_nxt   = f;
    cnt_nxt = '0;
    if (!filt_en) begin
      f_nxt = din;
    end else if (din != f) begin
      if (cnt == CNT_LAST) begin
        f_nxt = din;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rise_nxt = f_nxt & ~f;
    fall_nxt = ~f_nxt & f;
    edge_nxt = f_nxt ^ f;
  end

endmodule

// File: rtl/c3lib_sync_deglitch.sv
// Per-bit deglitch filter and edge detector for an already-synchronized bus;
// every output is registered.
module c3lib_sync_deglitch
  import c3lib_deglitch_pkg::*;
#(
  parameter int DWIDTH        = 1,
  parameter int RESET_VAL     = 0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              filt_en,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic [DWIDTH-1:0] rise_pls,
  output logic [DWIDTH-1:0] fall_pls,
  output logic              chg_pls
);

  localparam logic RESET_BIT = reset_bit(RESET_VAL);

  if (!filter_cycles_legal(FILTER_CYCLES)) begin : g_bad_filter_cycles
    $error("c3lib_sync_deglitch: FILTER_CYCLES must be >= 1");
  end
  if (!dwidth_legal(DWIDTH)) begin : g_bad_dwidth
    $error("c3lib_sync_deglitch: DWIDTH must be >= 1");
  end

  logic [DWIDTH-1:0] edge_nxt;

  c3lib_deglitch_bit #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .RESET_BIT     (RESET_BIT)
  ) u_bit [DWIDTH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .filt_en  (filt_en),
    .din      (data_in),
    .f        (data_out),
    .rise     (rise_pls),
    .fall     (fall_pls),
    .edge_nxt (edge_nxt)
  );

  // Built from the bits' next-edge terms so chg_pls lands with the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_pls <= 1'b0;
    end else begin
      chg_pls <= |edge_nxt;
    end
  end

endmodule
